inst_fetch: RTL

//  Fetch stage placed directly upstream of the instruction ROM. Holds the PC and

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch_fifo.sv | 56 +++++
 rtl/inst_fetch.sv | 69 ++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants and the {pc, inst} entry type carried through the fetch buffer.
package inst_fetch_pkg;

  localparam int InstWidth   = 32;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = InstWidth;

  localparam logic [InstAddrBus-1:0] ZeroWord    = 32'h0000_0000;
  localparam logic [InstAddrBus-1:0] PcStep      = 32'd4;
  localparam logic                   ChipEnable  = 1'b1;
  localparam logic                   ChipDisable = 1'b0;
  localparam logic                   RstEnable   = 1'b0;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO with flush for fetched {pc, inst} entries; read data comes straight from storage.
// Latency: a push at edge N is visible on rdata after edge N; caller must not push when full without a pop.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // A pop in the flush cycle still completes; everything left is dropped.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  assign rdata = mem[head];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC register drives the ROM, returned words are buffered with their PC for decode.
// Latency: ROM word pushed at edge N is on id_* after edge N; PC stalls while the buffer is full and not draining.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  inst_addr_t   pc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  assign id_valid = ~empty;
  assign pop      = id_valid & id_ready;
  // Redirect overrides fetch: the word at the old pc is wrong-path.
  assign push     = rom_ce & ~redirect & (~full | pop);

  assign rom_addr = pc;
  assign wr_entry = '{pc: pc, inst: rom_inst};
  assign id_pc    = rd_entry.pc;
  assign id_inst  = rd_entry.inst;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      pc     <= RESET_PC;
      rom_ce <= ChipDisable;
    end else begin
      rom_ce <= ChipEnable;
      if (redirect) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        pc <= pc + PcStep;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect),
    .push (push),
    .wdata(wr_entry),
    .pop  (pop),
    .rdata(rd_entry),
    .full (full),
    .empty(empty)
  );

endmodule
